// File: rtl/click_join_sync.sv
// rtl/click_join_sync.sv - clocked 2-phase click join of channels A and B into one output token
module click_join_sync #(
    parameter int   DATA_WIDTH  = 8,
    parameter logic PHASE_INIT  = 1'b0,
    parameter int   SYNC_STAGES = 2,
    parameter int   COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inA_req,
    input  logic [DATA_WIDTH-1:0]   inA_data,
    output logic                    inA_ack,
    input  logic                    inB_req,
    input  logic [DATA_WIDTH-1:0]   inB_data,
    output logic                    inB_ack,
    output logic                    out_req,
    output logic [2*DATA_WIDTH-1:0] out_data,
    input  logic                    out_ack,
    output logic [COUNT_WIDTH-1:0]  join_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [SYNC_STAGES-1:0] SYNC_INIT = {SYNC_STAGES{PHASE_INIT}};

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0]  sync_b_q, sync_b_d;
    logic [SYNC_STAGES-1:0]  sync_o_q, sync_o_d;
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic                    out_req_q, out_req_d;
    logic [2*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    logic a_pending, b_pending, out_done;

    // Only the last stage of each synchronizer is ever looked at by control logic.
    assign a_pending = sync_a_q[SYNC_STAGES-1] != ack_a_q;
    assign b_pending = sync_b_q[SYNC_STAGES-1] != ack_b_q;
    assign out_done  = sync_o_q[SYNC_STAGES-1] == out_req_q;

    always_comb begin
        state_d    = state_q;
        sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], inA_req};
        sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], inB_req};
        sync_o_d   = {sync_o_q[SYNC_STAGES-2:0], out_ack};
        ack_a_d    = ack_a_q;
        ack_b_d    = ack_b_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (a_pending && b_pending) begin
                    out_data_d = {inB_data, inA_data};
                    out_req_d  = ~out_req_q;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // Both inputs are released on the same edge once downstream consumed the token.
                if (out_done) begin
                    ack_a_d = ~ack_a_q;
                    ack_b_d = ~ack_b_q;
                    count_d = count_q + COUNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_a_q   <= SYNC_INIT;
            sync_b_q   <= SYNC_INIT;
            sync_o_q   <= SYNC_INIT;
            ack_a_q    <= PHASE_INIT;
            ack_b_q    <= PHASE_INIT;
            out_req_q  <= PHASE_INIT;
            out_data_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            sync_o_q   <= sync_o_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            count_q    <= count_d;
        end
    end

    assign inA_ack    = ack_a_q;
    assign inB_ack    = ack_b_q;
    assign out_req    = out_req_q;
    assign out_data   = out_data_q;
    assign join_count = count_q;

endmodule

// File: tb/tb_click_join_sync.sv
// tb/tb_click_join_sync.sv - directed self-checking bench for click_join_sync
module tb_click_join_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests = 0;
    int   fails = 0;

    // dut0: defaults
    logic        a0_req, b0_req, oack0, a0_ack, b0_ack, oreq0;
    logic [7:0]  a0_data, b0_data;
    logic [15:0] odata0, cnt0;
    // dut1: PHASE_INIT=1
    logic        a1_req, b1_req, oack1, a1_ack, b1_ack, oreq1;
    logic [7:0]  a1_data, b1_data;
    logic [15:0] odata1, cnt1;
    // dut2: COUNT_WIDTH=2
    logic        a2_req, b2_req, oack2, a2_ack, b2_ack, oreq2;
    logic [7:0]  a2_data, b2_data;
    logic [15:0] odata2;
    logic [1:0]  cnt2;

    click_join_sync dut0 (
        .clk(clk), .rst(rst),
        .inA_req(a0_req), .inA_data(a0_data), .inA_ack(a0_ack),
        .inB_req(b0_req), .inB_data(b0_data), .inB_ack(b0_ack),
        .out_req(oreq0), .out_data(odata0), .out_ack(oack0), .join_count(cnt0)
    );

    click_join_sync #(.PHASE_INIT(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .inA_req(a1_req), .inA_data(a1_data), .inA_ack(a1_ack),
        .inB_req(b1_req), .inB_data(b1_data), .inB_ack(b1_ack),
        .out_req(oreq1), .out_data(odata1), .out_ack(oack1), .join_count(cnt1)
    );

    click_join_sync #(.COUNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .inA_req(a2_req), .inA_data(a2_data), .inA_ack(a2_ack),
        .inB_req(b2_req), .inB_data(b2_data), .inB_ack(b2_ack),
        .out_req(oreq2), .out_data(odata2), .out_ack(oack2), .join_count(cnt2)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a0_req = 1'b0; b0_req = 1'b0; oack0 = 1'b0; a0_data = 8'h00; b0_data = 8'h00;
        a1_req = 1'b1; b1_req = 1'b1; oack1 = 1'b1; a1_data = 8'h00; b1_data = 8'h00;
        a2_req = 1'b0; b2_req = 1'b0; oack2 = 1'b0; a2_data = 8'h00; b2_data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({a0_ack, b0_ack, oreq0} !== 3'b000 || odata0 !== 16'h0 || cnt0 !== 16'h0) begin
            fails++;
            $display("FAIL reset0: got ack=%b%b req=%b data=%h cnt=%0d, want 0 0 0 0000 0",
                     a0_ack, b0_ack, oreq0, odata0, cnt0);
        end
        tests++;
        if ({a1_ack, b1_ack, oreq1} !== 3'b111 || odata1 !== 16'h0 || cnt1 !== 16'h0) begin
            fails++;
            $display("FAIL reset1: got ack=%b%b req=%b data=%h cnt=%0d, want 1 1 1 0000 0",
                     a1_ack, b1_ack, oreq1, odata1, cnt1);
        end
        // put dut0 into SEND, then reset it mid-transfer
        a0_data = 8'h11; b0_data = 8'h22; a0_req = 1'b1; b0_req = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_send: out_req got %b want 1", oreq0);
        end
        rst = 1'b1; a0_req = 1'b0; b0_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a0_ack, b0_ack, oreq0} !== 3'b000 || odata0 !== 16'h0 || cnt0 !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid_send: got ack=%b%b req=%b data=%h cnt=%0d, want 0 0 0 0000 0",
                     a0_ack, b0_ack, oreq0, odata0, cnt0);
        end
        repeat (10) @(negedge clk);
        tests++;
        if ({a0_ack, b0_ack, oreq0} !== 3'b000) begin
            fails++;
            $display("FAIL reset_quiet: got ack=%b%b req=%b want 000", a0_ack, b0_ack, oreq0);
        end
        // state must be IDLE: a fresh join starts with normal latency
        a0_data = 8'h5A; b0_data = 8'hA5; a0_req = 1'b1; b0_req = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b1 || odata0 !== 16'hA55A) begin
            fails++;
            $display("FAIL reset_idle_join: got req=%b data=%h want 1 a55a", oreq0, odata0);
        end
    endtask

    task automatic test_single_pending();
        do_reset();
        a0_data = 8'h12; a0_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (oreq0 !== 1'b0 || a0_ack !== 1'b0) begin
                fails++;
                $display("FAIL single_wait cyc%0d: got req=%b ackA=%b want 0 0", i, oreq0, a0_ack);
            end
        end
        b0_data = 8'h34; b0_req = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b0) begin
            fails++;
            $display("FAIL single_early: out_req got %b want 0 after 2 edges", oreq0);
        end
        @(negedge clk);
        tests++;
        if (oreq0 !== 1'b1 || odata0 !== 16'h3412) begin
            fails++;
            $display("FAIL single_join: got req=%b data=%h want 1 3412", oreq0, odata0);
        end
        oack0 = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (a0_ack !== 1'b1 || b0_ack !== 1'b1 || cnt0 !== 16'd1) begin
            fails++;
            $display("FAIL single_ack: got ack=%b%b cnt=%0d want 11 1", a0_ack, b0_ack, cnt0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        a0_data = 8'hAA; b0_data = 8'h55; a0_req = 1'b1; b0_req = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b0) begin
            fails++;
            $display("FAIL simul_early: out_req got %b want 0", oreq0);
        end
        @(negedge clk);
        tests++;
        if (oreq0 !== 1'b1 || odata0 !== 16'h55AA) begin
            fails++;
            $display("FAIL simul_join: got req=%b data=%h want 1 55aa", oreq0, odata0);
        end
        repeat (10) @(negedge clk);
        oack0 = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (a0_ack !== 1'b0 || b0_ack !== 1'b0) begin
            fails++;
            $display("FAIL simul_ack_early: got ack=%b%b want 00", a0_ack, b0_ack);
        end
        @(negedge clk);
        tests++;
        if (a0_ack !== 1'b1 || b0_ack !== 1'b1 || cnt0 !== 16'd1) begin
            fails++;
            $display("FAIL simul_ack: got ack=%b%b cnt=%0d want 11 1", a0_ack, b0_ack, cnt0);
        end
    endtask

    task automatic test_delayed_ack();
        int bad;
        do_reset();
        a0_data = 8'h01; b0_data = 8'h02; a0_req = 1'b1; b0_req = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b1 || odata0 !== 16'h0201) begin
            fails++;
            $display("FAIL delay_join: got req=%b data=%h want 1 0201", oreq0, odata0);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 5) begin
                a0_data = 8'hF0; b0_data = 8'h0F;
            end
            if (odata0 !== 16'h0201 || a0_ack !== 1'b0 || b0_ack !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL delay_hold: %0d cycles with data/ack change, want 0 (last data=%h)", bad, odata0);
        end
        oack0 = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (a0_ack !== 1'b1 || b0_ack !== 1'b1 || cnt0 !== 16'd1 || oreq0 !== 1'b1) begin
            fails++;
            $display("FAIL delay_ack: got ack=%b%b cnt=%0d req=%b want 11 1 1", a0_ack, b0_ack, cnt0, oreq0);
        end
        a0_req = 1'b0; b0_req = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (oreq0 !== 1'b0 || odata0 !== 16'h0FF0) begin
            fails++;
            $display("FAIL delay_next: got req=%b data=%h want 0 0ff0", oreq0, odata0);
        end
    endtask

    localparam logic [7:0] AV [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
    localparam logic [7:0] BV [4] = '{8'hC0, 8'hD1, 8'hE2, 8'hF3};

    task automatic test_back_to_back();
        int   k, ntog, ack_tog, oack_tog;
        logic prev_req, prev_ack;
        do_reset();
        k = 0; ntog = 0; ack_tog = 0; oack_tog = 0;
        prev_req = oreq1; prev_ack = a1_ack;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (oreq1 !== prev_req) begin
                tests++;
                if (ntog >= 4 || odata1 !== {BV[ntog & 3], AV[ntog & 3]}) begin
                    fails++;
                    $display("FAIL b2b_data%0d: got %h want %h", ntog, odata1, {BV[ntog & 3], AV[ntog & 3]});
                end
                ntog++;
                prev_req = oreq1;
            end
            if (a1_ack !== prev_ack) begin
                tests++;
                if (ack_tog >= oack_tog || b1_ack !== a1_ack) begin
                    fails++;
                    $display("FAIL b2b_ack_order%0d: ack toggles=%0d out_ack toggles=%0d ackB=%b want ack<out_ack, ackB=%b",
                             ack_tog, ack_tog + 1, oack_tog, b1_ack, a1_ack);
                end
                ack_tog++;
                prev_ack = a1_ack;
            end
            if (oack1 !== oreq1) begin
                oack1 = oreq1;
                oack_tog++;
            end
            if (k < 4 && a1_ack === a1_req && b1_ack === b1_req) begin
                a1_data = AV[k]; b1_data = BV[k];
                a1_req = ~a1_req; b1_req = ~b1_req;
                k++;
            end
            if (k == 4 && ack_tog == 4) break;
        end
        tests++;
        if (ntog != 4 || oreq1 !== 1'b1 || ack_tog != 4) begin
            fails++;
            $display("FAIL b2b_toggles: got req toggles=%0d final=%b ack toggles=%0d want 4 1 4", ntog, oreq1, ack_tog);
        end
        tests++;
        if (cnt1 !== 16'd4) begin
            fails++;
            $display("FAIL b2b_count: got %0d want 4", cnt1);
        end
    endtask

    localparam logic [1:0] CNT_EXP [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic test_count_wrap();
        int   cyc;
        logic prev;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            prev = oreq2;
            a2_data = 8'(i); b2_data = 8'(i + 8'h80);
            a2_req = ~a2_req; b2_req = ~b2_req;
            cyc = 0;
            while (oreq2 === prev && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            oack2 = oreq2;
            while (a2_ack !== a2_req && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            tests++;
            if (cyc >= 40 || cnt2 !== CNT_EXP[i]) begin
                fails++;
                $display("FAIL wrap_count%0d: got %0d (cycles=%0d) want %0d", i, cnt2, cyc, CNT_EXP[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a0_req = 1'b0; b0_req = 1'b0; oack0 = 1'b0; a0_data = 8'h00; b0_data = 8'h00;
        a1_req = 1'b1; b1_req = 1'b1; oack1 = 1'b1; a1_data = 8'h00; b1_data = 8'h00;
        a2_req = 1'b0; b2_req = 1'b0; oack2 = 1'b0; a2_data = 8'h00; b2_data = 8'h00;
        test_reset();
        test_single_pending();
        test_simultaneous();
        test_delayed_ack();
        test_back_to_back();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
